// File: rtl/knight_trail.sv
// knight_trail: turns the knight flasher's pattern into a fading comet tail.
// Each pattern step reloads lit LEDs to full brightness and decays the rest;
// a shared free-running counter turns the per-LED levels into PWM drive.
//
// Handshake: there is no back-pressure. A step strobe is consumed on the
// rising clock edge where step=1; pat is ignored on every other edge.
// Back-to-back steps are legal and each one applies a full update.
module knight_trail #(
    parameter int WIDTH  = 8,
    parameter int LEVELW = 3,
    parameter int DECAY  = 2
) (
    input  logic                     ck,
    input  logic                     res,
    input  logic                     step,
    input  logic [WIDTH-1:0]         pat,
    output logic [WIDTH-1:0]         led,
    output logic [WIDTH*LEVELW-1:0]  lvl,
    output logic                     wrap
);

    // Full brightness, the per-step decay, and the last PWM count.
    localparam logic [LEVELW-1:0] MAX  = {LEVELW{1'b1}};
    localparam logic [LEVELW-1:0] DEC  = LEVELW'(DECAY);
    localparam logic [LEVELW-1:0] LAST = MAX - 1'b1;

    logic [LEVELW-1:0] cnt;
    logic [LEVELW-1:0] level      [WIDTH];
    logic [LEVELW-1:0] level_next [WIDTH];
    logic [WIDTH-1:0]  led_next;

    // PWM counter runs 0..MAX-1 so that level MAX is always on and 0 always off.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= (cnt == LAST);
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next level per LED (saturating decay as a compare) and PWM compare
    // against the levels as they stand before the edge.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            level_next[i] = level[i];
            if (step) begin
                if (pat[i]) begin
                    level_next[i] = MAX;
                end else if (level[i] <= DEC) begin
                    level_next[i] = '0;
                end else begin
                    level_next[i] = level[i] - DEC;
                end
            end
            led_next[i] = (cnt < level[i]);
        end
    end

    // Level registers and registered LED drive; no path from pat/step to led.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            for (int i = 0; i < WIDTH; i++) begin
                level[i] <= '0;
            end
            led <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                level[i] <= level_next[i];
            end
            led <= led_next;
        end
    end

    // Flatten the level array onto the debug bus, LED i at [i*LEVELW +: LEVELW].
    for (genvar g = 0; g < WIDTH; g++) begin : g_lvl
        assign lvl[g*LEVELW +: LEVELW] = level[g];
    end

endmodule

// File: tb/tb_knight_trail.sv
// Bench for knight_trail (WIDTH=8, LEVELW=3, DECAY=2) with a behavioural
// model of brightness levels, period-7 PWM and the wrap pulse.
module tb_knight_trail;

  localparam int W    = 8;
  localparam int LW   = 3;
  localparam int MAXL = 7;
  localparam int DEC  = 2;

  logic            ck   = 1'b0;
  logic            res  = 1'b1;
  logic            step = 1'b0;
  logic [W-1:0]    pat  = '0;
  logic [W-1:0]    led;
  logic [W*LW-1:0] lvl;
  logic            wrap;

  int n_checks = 0;
  int n_fail   = 0;

  knight_trail #(.WIDTH(W), .LEVELW(LW), .DECAY(DEC)) dut (
    .ck(ck), .res(res), .step(step), .pat(pat),
    .led(led), .lvl(lvl), .wrap(wrap)
  );

  // clock / reset block
  always #5 ck = ~ck;

  // reference model: levels as integers, PWM phase as cycles-since-release mod 7
  int              m_lvl[W];
  int              m_cnt = 0;
  logic [W-1:0]    m_led = '0;
  logic            m_wrap = 1'b0;
  logic [W*LW-1:0] exp_lvl = '0;

  always @(posedge ck or posedge res) begin
    if (res) begin
      for (int i = 0; i < W; i++) m_lvl[i] = 0;
      m_cnt  = 0;
      m_led  = '0;
      m_wrap = 1'b0;
    end else begin
      for (int i = 0; i < W; i++) m_led[i] = (m_cnt < m_lvl[i]);
      m_wrap = (m_cnt == MAXL - 1);
      m_cnt  = (m_cnt + 1) % MAXL;
      if (step) begin
        for (int i = 0; i < W; i++)
          m_lvl[i] = pat[i] ? MAXL : ((m_lvl[i] > DEC) ? m_lvl[i] - DEC : 0);
      end
    end
    for (int i = 0; i < W; i++) exp_lvl[i*LW +: LW] = 3'(m_lvl[i]);
  end

  function automatic int lvl_of(input logic [W*LW-1:0] bus, input int i);
    return int'(bus[i*LW +: LW]);
  endfunction

  // driver tasks: inputs change on the falling edge only
  task automatic apply_step(input logic [W-1:0] p);
    pat  = p;
    step = 1'b1;
    @(negedge ck);
    step = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) @(negedge ck);
    n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", led); end
    n_checks++; if (lvl !== '0) begin n_fail++; $display("FAIL reset_lvl: got %h want 0", lvl); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    res = 1'b0;
  endtask

  task automatic test_single_load();
    apply_step(8'h01);
    n_checks++; if (lvl_of(lvl, 0) != MAXL) begin n_fail++; $display("FAIL load_lvl0: got %0d want 7", lvl_of(lvl, 0)); end
    n_checks++; if (lvl[W*LW-1:LW] !== '0) begin n_fail++; $display("FAIL load_others: got %h want 0", lvl[W*LW-1:LW]); end
    for (int c = 0; c < 14; c++) begin
      @(negedge ck);
      n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL load_led c=%0d: got %h want 01", c, led); end
    end
  endtask

  task automatic test_decay_pwm();
    int exp0[5] = '{5, 3, 1, 0, 0};
    logic [W-1:0] pats[5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    for (int k = 0; k < 5; k++) begin
      apply_step(pats[k]);
      n_checks++; if (lvl_of(lvl, 0) != exp0[k]) begin n_fail++; $display("FAIL decay_lvl0 k=%0d: got %0d want %0d", k, lvl_of(lvl, 0), exp0[k]); end
      n_checks++; if (lvl !== exp_lvl) begin n_fail++; $display("FAIL decay_bus k=%0d: got %h want %h", k, lvl, exp_lvl); end
      if (k == 0) begin
        int ones = 0;
        for (int j = 0; j < MAXL; j++) begin
          int pc;
          @(negedge ck);
          pc = (m_cnt + MAXL - 1) % MAXL;
          if (led[0]) ones++;
          n_checks++; if (led[0] !== (pc < 5)) begin n_fail++; $display("FAIL duty5_phase cnt=%0d: got %b want %b", pc, led[0], (pc < 5)); end
        end
        n_checks++; if (ones != 5) begin n_fail++; $display("FAIL duty5_count: got %0d want 5", ones); end
      end
    end
  endtask

  task automatic test_sweep();
    int seq[15];
    int prev1 = -1;
    int prev2 = -1;
    for (int i = 0; i < 8; i++) seq[i] = i;
    for (int i = 0; i < 7; i++) seq[8+i] = 6 - i;
    for (int s = 0; s < 15; s++) begin
      int pos = seq[s];
      apply_step(8'(1 << pos));
      n_checks++; if (lvl_of(lvl, pos) != 7) begin n_fail++; $display("FAIL sweep_lit s=%0d: got %0d want 7", s, lvl_of(lvl, pos)); end
      if (prev1 >= 0 && prev1 != pos) begin
        n_checks++; if (lvl_of(lvl, prev1) != 5) begin n_fail++; $display("FAIL sweep_behind1 s=%0d: got %0d want 5", s, lvl_of(lvl, prev1)); end
      end
      if (prev2 >= 0 && prev2 != pos && prev2 != prev1) begin
        n_checks++; if (lvl_of(lvl, prev2) != 3) begin n_fail++; $display("FAIL sweep_behind2 s=%0d: got %0d want 3", s, lvl_of(lvl, prev2)); end
      end
      n_checks++; if (lvl !== exp_lvl) begin n_fail++; $display("FAIL sweep_bus s=%0d: got %h want %h", s, lvl, exp_lvl); end
      for (int c = 0; c < 13; c++) begin
        @(negedge ck);
        n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL sweep_led s=%0d: got %h want %h", s, led, m_led); end
      end
      prev2 = prev1;
      prev1 = pos;
    end
  endtask

  task automatic test_gating();
    logic [W*LW-1:0] saved = lvl;
    for (int c = 0; c < 14; c++) begin
      pat = 8'($urandom);
      @(negedge ck);
      n_checks++; if (lvl !== saved) begin n_fail++; $display("FAIL gate_hold c=%0d: got %h want %h", c, lvl, saved); end
      n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL gate_led c=%0d: got %h want %h", c, led, m_led); end
    end
    apply_step(8'hFF);
    n_checks++; if (lvl !== 24'hFFFFFF) begin n_fail++; $display("FAIL all_on_lvl: got %h want ffffff", lvl); end
    @(negedge ck);
    n_checks++; if (led !== 8'hFF) begin n_fail++; $display("FAIL all_on_led: got %h want ff", led); end
  endtask

  task automatic test_wrap();
    int n_wrap = 0;
    int last = -1;
    bit found = 0;
    logic [W-1:0] p;
    for (int c = 0; c < 70; c++) begin
      @(negedge ck);
      if (wrap === 1'b1) begin
        if (last >= 0) begin
          n_checks++; if (c - last != 7) begin n_fail++; $display("FAIL wrap_spacing: got %0d want 7", c - last); end
        end
        last = c;
        n_wrap++;
      end
    end
    n_checks++; if (n_wrap != 10) begin n_fail++; $display("FAIL wrap_count: got %0d want 10", n_wrap); end
    for (int c = 0; c < 10 && !found; c++) begin
      if (m_cnt == MAXL - 1) found = 1;
      else @(negedge ck);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL wrap_align: got timeout want phase 6"); end
    p = 8'($urandom);
    apply_step(p);
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_step_pulse: got %b want 1", wrap); end
    n_checks++; if (lvl !== exp_lvl) begin n_fail++; $display("FAIL wrap_step_lvl: got %h want %h", lvl, exp_lvl); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      step = ($urandom_range(0, 2) == 0);
      pat  = 8'($urandom);
      @(negedge ck);
      n_checks++; if (lvl !== exp_lvl) begin n_fail++; $display("FAIL rand_lvl c=%0d: got %h want %h", c, lvl, exp_lvl); end
      n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL rand_led c=%0d: got %h want %h", c, led, m_led); end
      n_checks++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL rand_wrap c=%0d: got %b want %b", c, wrap, m_wrap); end
    end
    step = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    apply_step(8'hFF);
    @(negedge ck);
    n_checks++; if (led !== 8'hFF) begin n_fail++; $display("FAIL mid_pre_led: got %h want ff", led); end
    step = 1'b1;
    pat  = 8'($urandom);
    #2 res = 1'b1;
    #1;
    n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL async_led: got %h want 00", led); end
    n_checks++; if (lvl !== '0) begin n_fail++; $display("FAIL async_lvl: got %h want 0", lvl); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL async_wrap: got %b want 0", wrap); end
    @(negedge ck);
    @(negedge ck);
    step = 1'b0;
    res  = 1'b0;
    for (int c = 1; c <= 20 && first < 0; c++) begin
      @(negedge ck);
      if (wrap === 1'b1) first = c;
    end
    n_checks++; if (first != 7) begin n_fail++; $display("FAIL first_wrap: got %0d want 7", first); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_decay_pwm();
    test_sweep();
    test_gating();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
